muldiv_unit: RTL and testbench
==============================

# muldiv_unit

- Iterative multiply/divide unit in the EX stage, alongside the ALU.
- Takes the same two 32-bit operands the ID/EX register presents to the ALU and performs MULT, MULTU, DIV and DIVU over 33 cycles.
- Results go to architectural HI/LO registers, which feed the EX result mux for MFHI/MFLO.
- R_busy drives the pipeline hazard unit, which stalls IF/ID/EX while a multi-cycle operation is in flight.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- W_clk  in  1  clock; all state changes on rising edge.
- W_rst_n  in  1  asynchronous, active-low reset.
- W_start  in  1  request; sampled only when R_busy=0.
- W_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- W_a  in  WIDTH  operand rs (multiplicand / dividend / MTHI-MTLO source).
- W_b  in  WIDTH  operand rt (multiplier / divisor).
- W_cancel  in  1  abort in-flight operation (exception/flush).
- R_busy  out  1  operation in flight; stall request.
- R_done  out  1  one-cycle pulse: HI/LO just updated by a mul/div.
- R_hi  out  WIDTH  HI register.
- R_lo  out  WIDTH  LO register.

## Operation
**Reset.** W_rst_n=0 immediately forces:
- state IDLE;
- R_busy=0, R_done=0;
- R_hi=0, R_lo=0;
- all internal accumulators 0.

**States.** IDLE, MUL, DIV, FIX.
- IDLE:
  - W_start=1 with op MULT/MULTU: latch operands, go to MUL.
  - W_start=1 with op DIV/DIVU: latch operands, go to DIV.
  - MTHI writes R_hi<=W_a in the same edge; MTLO writes R_lo<=W_a. State stays IDLE, no R_done, R_busy stays 0.
  - Ops 110/111: no effect.
- MUL/DIV: 32 iterations, one per cycle, counter 0..31; after iteration 31, go to FIX.
- FIX:
  - apply sign correction;
  - write R_hi/R_lo;
  - set R_done=1 for the next cycle;
  - return to IDLE.
- W_cancel=1 in MUL/DIV/FIX: go to IDLE next edge; R_hi/R_lo unchanged; no R_done. W_cancel in IDLE has no effect, including on a same-cycle start.
- W_start while R_busy=1 is ignored, not queued. The hazard unit holds the instruction, so it is reissued.

**Arithmetic.**
- Signed ops (MULT, DIV): operate on magnitudes |a| and |b|, computed in 33-bit form so 0x80000000 is exact.
- MULT/MULTU:
  - shift-add, 64-bit product;
  - {R_hi,R_lo} = product;
  - MULT product is negated in FIX when the operand signs differ.
- DIV/DIVU: restoring division.
  - R_lo = quotient, R_hi = remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.
- Divide by zero (W_b=0): LO=0xFFFFFFFF, HI=W_a, for both DIV and DIVU. Latency is unchanged; no exception is raised.

## Timing
- Start accepted at edge E0. R_busy=1 from after E0 through edge E33.
- Iterations occur on edges E1..E32. FIX writes HI/LO at E33.
- In the cycle after E33: R_busy=0 and R_done=1.
- Result latency is 34 cycles from accept to R_done. A new start is accepted at E34, back-to-back.
- R_hi/R_lo are stable throughout R_busy=1; they never expose partial results.
- MTHI/MTLO: value visible on R_hi/R_lo in the cycle after the accepting edge; 1-cycle latency.
- R_done is never asserted for MTHI/MTLO, cancel, or reset.
- Reset asserted mid-operation: outputs drop to reset values asynchronously. The operation is lost; no R_done after release.
- First edge after W_rst_n deasserts: unit is in IDLE and can accept a start.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5 -> after 34 cycles R_done pulses; HI=0xFFFFFFFF, LO=0xFFFFFFF1; R_busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then immediately MULT 0x80000000×0x80000000 accepted at E34 -> HI=0x40000000, LO=0.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- MTHI 0x1234 then MTLO 0xABCD on consecutive cycles -> R_hi=0x1234, R_lo=0xABCD one cycle after each; no R_done.
- DIVU 100/7 started, second start (MULT) at cycle 5 is ignored; W_cancel at cycle 10 -> IDLE, HI/LO keep previous values, no R_done.
- Repeat with W_rst_n pulsed low at cycle 20 -> HI=LO=0, R_busy=0 asynchronously; a fresh DIVU 100/7 then gives LO=14, HI=2.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a final sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             W_clk,
  input  logic             W_rst_n,
  input  logic             W_start,
  input  logic [2:0]       W_op,
  input  logic [WIDTH-1:0] W_a,
  input  logic [WIDTH-1:0] W_b,
  input  logic             W_cancel,
  output logic             R_busy,
  output logic             R_done,
  output logic [WIDTH-1:0] R_hi,
  output logic [WIDTH-1:0] R_lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;     // partial product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;     // multiplier being shifted out / quotient being shifted in
  logic [WIDTH:0]   opnd_b;     // magnitude of rt, 33 bits so 0x80000000 is exact
  logic [WIDTH-1:0] a_raw;
  logic             is_div;
  logic             neg_lo;
  logic             neg_hi;
  logic             div_zero;

  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH:0] v);
    return v[WIDTH] ? -v : v;
  endfunction

  logic             op_signed;
  logic             op_mul;
  logic             op_div;
  logic [WIDTH:0]   a_mag;
  logic [WIDTH:0]   b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign op_signed = (W_op == OP_MULT) || (W_op == OP_DIV);
  assign op_mul    = (W_op == OP_MULT) || (W_op == OP_MULTU);
  assign op_div    = (W_op == OP_DIV)  || (W_op == OP_DIVU);
  assign a_mag     = magnitude({op_signed & W_a[WIDTH-1], W_a});
  assign b_mag     = magnitude({op_signed & W_b[WIDTH-1], W_b});

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? opnd_b : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= opnd_b;

  assign prod_fix  = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix   = neg_lo ? -acc_lo : acc_lo;
  assign rem_fix   = neg_hi ? -acc_hi : acc_hi;

  assign R_busy    = (state != S_IDLE);

  always_ff @(posedge W_clk or negedge W_rst_n) begin
    if (!W_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (W_start && op_mul)      state_nxt = S_MUL;
        else if (W_start && op_div) state_nxt = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (W_cancel)               state_nxt = S_IDLE;
        else if (cnt == LAST_ITER)  state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the later R_done write overrides the default.
  always_ff @(posedge W_clk or negedge W_rst_n) begin
    if (!W_rst_n) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd_b   <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      R_done   <= 1'b0;
      R_hi     <= '0;
      R_lo     <= '0;
    end else begin
      R_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (W_start) begin
            if (op_mul || op_div) begin
              cnt      <= '0;
              acc_hi   <= '0;
              acc_lo   <= WIDTH'(a_mag);
              opnd_b   <= b_mag;
              a_raw    <= W_a;
              is_div   <= op_div;
              neg_lo   <= op_signed & (W_a[WIDTH-1] ^ W_b[WIDTH-1]);
              neg_hi   <= op_signed & W_a[WIDTH-1];
              div_zero <= (W_b == '0);
            end else if (W_op == OP_MTHI) begin
              R_hi <= W_a;
            end else if (W_op == OP_MTLO) begin
              R_lo <= W_a;
            end
          end
        end
        S_MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
        end
        S_DIV: begin
          acc_hi <= div_ge ? WIDTH'(div_shift - opnd_b) : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          cnt    <= cnt + 1'b1;
        end
        S_FIX: begin
          if (!W_cancel) begin
            R_done <= 1'b1;
            if (!is_div) begin
              {R_hi, R_lo} <= prod_fix;
            end else if (div_zero) begin
              R_hi <= a_raw;
              R_lo <= '1;
            end else begin
              R_hi <= rem_fix;
              R_lo <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, hand-written corner sequences,
// and randomized operations against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        W_clk, W_rst_n, W_start, W_cancel;
  logic [2:0]  W_op;
  logic [31:0] W_a, W_b;
  logic        R_busy, R_done;
  logic [31:0] R_hi, R_lo;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .W_clk(W_clk), .W_rst_n(W_rst_n), .W_start(W_start), .W_op(W_op),
    .W_a(W_a), .W_b(W_b), .W_cancel(W_cancel),
    .R_busy(R_busy), .R_done(R_done), .R_hi(R_hi), .R_lo(R_lo)
  );

  initial W_clk = 1'b0;
  always #5 W_clk = ~W_clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic from the instruction semantics.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    logic [63:0]     p;
    hi = '0;
    lo = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = ua * ub;      hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      3'd3: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
      end
      default: ;
    endcase
  endfunction

  // Issue one mul/div and follow it to completion; sampling is 1 time unit after each rising edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit with_cancel,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int busy_n, output bit done_ok, output bit stable);
    logic [31:0] h0, l0;
    @(negedge W_clk);
    h0 = R_hi;
    l0 = R_lo;
    W_start = 1'b1; W_op = op; W_a = a; W_b = b; W_cancel = with_cancel;
    @(posedge W_clk); #1;
    W_start = 1'b0; W_cancel = 1'b0;
    busy_n = 0;
    stable = 1'b1;
    while (R_busy && busy_n < 100) begin
      if (R_hi !== h0 || R_lo !== l0 || R_done !== 1'b0) stable = 1'b0;
      busy_n++;
      @(posedge W_clk); #1;
    end
    done_ok = (R_done === 1'b1);
    hi = R_hi;
    lo = R_lo;
  endtask

  task automatic exec_check(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit with_cancel,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi, lo;
    int          busy_n;
    bit          done_ok, stable;
    run_op(op, a, b, with_cancel, hi, lo, busy_n, done_ok, stable);
    check({name, " hi"}, 64'(hi), 64'(exp_hi));
    check({name, " lo"}, 64'(lo), 64'(exp_lo));
    check({name, " busy_cycles"}, 64'(busy_n), 64'd33);
    check({name, " done"}, 64'(done_ok), 64'd1);
    check({name, " hilo_stable"}, 64'(stable), 64'd1);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] eh, el;
    int          done_cnt;

    vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[6] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[8] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    W_rst_n = 1'b0; W_start = 1'b0; W_cancel = 1'b0; W_op = '0; W_a = '0; W_b = '0;
    #12;
    check("reset busy", 64'(R_busy), 64'd0);
    check("reset done", 64'(R_done), 64'd0);
    check("reset hi",   64'(R_hi),   64'd0);
    check("reset lo",   64'(R_lo),   64'd0);
    W_rst_n = 1'b1;

    // Directed table, back-to-back (each start lands on the edge after the previous R_done edge).
    foreach (vecs[i])
      exec_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].hi, vecs[i].lo);
    @(posedge W_clk); #1;
    check("done single pulse", 64'(R_done), 64'd0);

    // MTHI then MTLO on consecutive cycles, then an ignored op code.
    @(negedge W_clk);
    W_start = 1'b1; W_op = 3'b100; W_a = 32'h1234;
    @(posedge W_clk); #1;
    check("mthi hi",   64'(R_hi),   64'h1234);
    check("mthi busy", 64'(R_busy), 64'd0);
    check("mthi done", 64'(R_done), 64'd0);
    @(negedge W_clk);
    W_op = 3'b101; W_a = 32'hABCD;
    @(posedge W_clk); #1;
    check("mtlo lo",   64'(R_lo),   64'hABCD);
    check("mtlo hi",   64'(R_hi),   64'h1234);
    check("mtlo done", 64'(R_done), 64'd0);
    @(negedge W_clk);
    W_op = 3'b110; W_a = 32'h5555_5555;
    @(posedge W_clk); #1;
    W_start = 1'b0;
    check("op110 hilo", {R_hi, R_lo}, {32'h1234, 32'hABCD});
    check("op110 busy", 64'(R_busy), 64'd0);

    // DIVU 100/7, ignored MULT start at cycle 5, cancel at cycle 10.
    @(negedge W_clk);
    W_start = 1'b1; W_op = 3'b011; W_a = 32'd100; W_b = 32'd7;
    @(posedge W_clk); #1;
    W_start = 1'b0;
    check("cancel seq busy", 64'(R_busy), 64'd1);
    repeat (4) @(posedge W_clk);
    @(negedge W_clk);
    W_start = 1'b1; W_op = 3'b000; W_a = 32'd3; W_b = 32'd5;
    @(posedge W_clk); #1;
    W_start = 1'b0;
    check("busy start ignored", 64'(R_busy), 64'd1);
    repeat (4) @(posedge W_clk);
    @(negedge W_clk);
    W_cancel = 1'b1;
    @(posedge W_clk); #1;
    W_cancel = 1'b0;
    check("cancel busy", 64'(R_busy), 64'd0);
    check("cancel hilo", {R_hi, R_lo}, {32'h1234, 32'hABCD});
    done_cnt = 0;
    repeat (40) begin
      @(posedge W_clk); #1;
      if (R_done || R_busy) done_cnt++;
    end
    check("cancel no done/restart", 64'(done_cnt), 64'd0);
    check("cancel hilo later", {R_hi, R_lo}, {32'h1234, 32'hABCD});

    // Same sequence with an asynchronous reset mid-operation.
    @(negedge W_clk);
    W_start = 1'b1; W_op = 3'b011; W_a = 32'd100; W_b = 32'd7;
    @(posedge W_clk); #1;
    W_start = 1'b0;
    repeat (19) @(posedge W_clk);
    @(negedge W_clk);
    W_rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(R_busy), 64'd0);
    check("async rst hilo", {R_hi, R_lo}, 64'd0);
    check("async rst done", 64'(R_done), 64'd0);
    @(negedge W_clk);
    W_rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(posedge W_clk); #1;
      if (R_done || R_busy) done_cnt++;
    end
    check("post rst no done", 64'(done_cnt), 64'd0);
    exec_check("divu after rst", 3'b011, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);

    // Cancel in IDLE does not block a same-cycle start.
    exec_check("idle cancel start", 3'b001, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      ref_op(op, a, b, eh, el);
      exec_check($sformatf("rand%0d op%0d a=%h b=%h", i, op, a, b), op, a, b, 1'b0, eh, el);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
